// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready handshake,
// stall (back-pressure), flush, NOP control insertion and a saturating stall counter.
// Optional feature: define PIPE_STAGE_SKID_EN to add a second (skid) entry, which
// makes in_ready_o a pure register and breaks the out_ready_i -> in_ready_o path.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W   = 143,
  parameter int unsigned       CTRL_W   = 14,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              in_xfer;
  logic              out_xfer;

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
  logic [1:0]        occupancy_q,  occupancy_d;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic              in_ready_q,   in_ready_d;

  assign in_ready_o = in_ready_q;
`else
  assign in_ready_o = ~main_valid_q | out_ready_i;
`endif

  assign in_xfer     = in_valid_i & in_ready_o;
  assign out_xfer    = main_valid_q & out_ready_i;

  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;
  assign out_ctrl_o  = main_ctrl_q;
  assign occupancy_o = occupancy_q;
  assign stall_cnt_o = stall_cnt_q;

`ifdef PIPE_STAGE_SKID_EN
  // Entry update: main refills from skid first (age order), then from the input; a beat that
  // arrives while main is full and stalled parks in skid; flush empties both entries.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (!main_valid_q || out_xfer) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_ctrl_d  = skid_ctrl_q;
        if (in_xfer) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data_i;
          skid_ctrl_d  = in_ctrl_i;
        end else begin
          skid_valid_d = 1'b0;
          skid_ctrl_d  = NOP_CTRL;
        end
      end else if (in_xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data_i;
        main_ctrl_d  = in_ctrl_i;
      end else begin
        main_valid_d = 1'b0;
        main_ctrl_d  = NOP_CTRL;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
      skid_ctrl_d  = in_ctrl_i;
    end
    if (flush_i) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = NOP_CTRL;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = NOP_CTRL;
    end
    in_ready_d = ~skid_valid_d;
  end
`else
  // Entry update: accept replaces main (also covers simultaneous in/out), a drain with no
  // refill turns the stage into a bubble, and flush discards everything including this cycle's beat.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    if (in_xfer) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data_i;
      main_ctrl_d  = in_ctrl_i;
    end else if (out_xfer) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = NOP_CTRL;
    end
    if (flush_i) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = NOP_CTRL;
    end
  end
`endif

  // Stall counter saturates at all-ones and only reset clears it; occupancy mirrors next entry state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
`ifdef PIPE_STAGE_SKID_EN
    occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
`else
    occupancy_d = {1'b0, main_valid_d};
`endif
  end

  // State registers with synchronous active-low reset that discards every held beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= NOP_CTRL;
      stall_cnt_q  <= '0;
      occupancy_q  <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= NOP_CTRL;
      in_ready_q   <= 1'b1;
`endif
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      stall_cnt_q  <= stall_cnt_d;
      occupancy_q  <= occupancy_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      in_ready_q   <= in_ready_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: table-driven directed test of pipe_stage_reg plus hand-written
// back-pressure, flush and saturation sequences. Builds with or without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 143;
  localparam int unsigned CW = 14;
  localparam logic [CW-1:0] NOP = 14'h2A5A;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct {
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          exp_ready;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_ctrl;
    logic [1:0]    exp_occ;
    logic [15:0]   exp_stall;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic [CW-1:0] in_ctrl_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [CW-1:0] out_ctrl_o;
  logic [1:0]    occupancy_o;
  logic [15:0]   stall_cnt_o;

  logic          sat_rst_n;
  logic          sat_flush;
  logic          sat_in_valid;
  logic          sat_in_ready;
  logic [7:0]    sat_in_data;
  logic [3:0]    sat_in_ctrl;
  logic          sat_out_valid;
  logic          sat_out_ready;
  logic [7:0]    sat_out_data;
  logic [3:0]    sat_out_ctrl;
  logic [1:0]    sat_occ;
  logic [3:0]    sat_stall;

  int checks   = 0;
  int failures = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_ctrl_o(out_ctrl_o),
    .occupancy_o(occupancy_o), .stall_cnt_o(stall_cnt_o)
  );

  pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .NOP_CTRL(4'h5), .CNT_W(4)) sat_dut (
    .clk(clk), .rst_n(sat_rst_n), .flush_i(sat_flush),
    .in_valid_i(sat_in_valid), .in_ready_o(sat_in_ready), .in_data_i(sat_in_data), .in_ctrl_i(sat_in_ctrl),
    .out_valid_o(sat_out_valid), .out_ready_i(sat_out_ready), .out_data_o(sat_out_data), .out_ctrl_o(sat_out_ctrl),
    .occupancy_o(sat_occ), .stall_cnt_o(sat_stall)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic rn, input logic fl, input logic iv, input logic [DW-1:0] d,
                              input logic [CW-1:0] c, input logic ordy, input logic er, input logic ev,
                              input logic [DW-1:0] ed, input logic [CW-1:0] ec, input logic [1:0] eo,
                              input logic [15:0] es);
    vec_t v;
    v.rst_n = rn; v.flush = fl; v.in_valid = iv; v.in_data = d; v.in_ctrl = c; v.out_ready = ordy;
    v.exp_ready = er; v.exp_valid = ev; v.exp_data = ed; v.exp_ctrl = ec; v.exp_occ = eo; v.exp_stall = es;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector, check in_ready before the edge, then the registered outputs after it.
  task automatic applyStimulus(input vec_t v, input string tag);
    rst_n       = v.rst_n;
    flush_i     = v.flush;
    in_valid_i  = v.in_valid;
    in_data_i   = v.in_data;
    in_ctrl_i   = v.in_ctrl;
    out_ready_i = v.out_ready;
    #1;
    checkOutput({tag, ".in_ready"}, {159'd0, in_ready_o}, {159'd0, v.exp_ready});
    @(posedge clk);
    #1;
    checkOutput({tag, ".out_valid"}, {159'd0, out_valid_o}, {159'd0, v.exp_valid});
    checkOutput({tag, ".out_data"}, {17'd0, out_data_o}, {17'd0, v.exp_data});
    checkOutput({tag, ".out_ctrl"}, {146'd0, out_ctrl_o}, {146'd0, v.exp_ctrl});
    checkOutput({tag, ".occupancy"}, {158'd0, occupancy_o}, {158'd0, v.exp_occ});
    checkOutput({tag, ".stall_cnt"}, {144'd0, stall_cnt_o}, {144'd0, v.exp_stall});
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_ctrl_i = '0; out_ready_i = 1'b1;
    sat_rst_n = 1'b0; sat_flush = 1'b0; sat_in_valid = 1'b0; sat_in_data = '0; sat_in_ctrl = '0;
    sat_out_ready = 1'b1;
    @(posedge clk);
    #1;

    //          rst  fl iv data   ctrl     ordy rdy  val data   ctrl     occ stall
    tbl.push_back(mk(0, 0, 1, 'h55, 14'h155, 1, 1,    0, 'h0,  NOP,     0, 0));
    tbl.push_back(mk(1, 0, 1, 'h1,  14'h101, 1, 1,    1, 'h1,  14'h101, 1, 0));
    tbl.push_back(mk(1, 0, 1, 'h2,  14'h102, 1, 1,    1, 'h2,  14'h102, 1, 0));
    tbl.push_back(mk(1, 0, 1, 'h3,  14'h103, 1, 1,    1, 'h3,  14'h103, 1, 0));
    tbl.push_back(mk(1, 0, 0, 'h0,  14'h0,   1, 1,    0, 'h3,  NOP,     0, 0));
    tbl.push_back(mk(1, 0, 1, 'hA,  14'h10A, 0, 1,    1, 'hA,  14'h10A, 1, 0));
    tbl.push_back(mk(1, 0, 0, 'h0,  14'h0,   0, SKID, 1, 'hA,  14'h10A, 1, 1));
    tbl.push_back(mk(1, 0, 0, 'h0,  14'h0,   0, SKID, 1, 'hA,  14'h10A, 1, 2));
    tbl.push_back(mk(1, 0, 0, 'h0,  14'h0,   1, 1,    0, 'hA,  NOP,     0, 2));
    tbl.push_back(mk(1, 0, 1, 'hB,  14'h10B, 1, 1,    1, 'hB,  14'h10B, 1, 2));
    tbl.push_back(mk(1, 1, 1, 'hC,  14'h10C, 0, SKID, 0, 'hB,  NOP,     0, 3));
    tbl.push_back(mk(1, 0, 0, 'h0,  14'h0,   1, 1,    0, 'hB,  NOP,     0, 3));
    tbl.push_back(mk(1, 0, 1, 'hD,  14'h10D, 1, 1,    1, 'hD,  14'h10D, 1, 3));
    tbl.push_back(mk(0, 0, 1, 'hE,  14'h10E, 0, SKID, 0, 'h0,  NOP,     0, 0));
    tbl.push_back(mk(1, 0, 1, {15'h7ABC, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D},
                     14'h3FFF, 1, 1, 1, {15'h7ABC, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D}, 14'h3FFF, 1, 0));
    foreach (tbl[i]) applyStimulus(tbl[i], $sformatf("v%0d", i));

    // Back-pressure on beat A with beat B waiting, then release.
    seq.push_back(mk(1, 0, 1, 'hA1, 14'h1A1, 1, 1, 1, 'hA1, 14'h1A1, 1, 0));
`ifdef PIPE_STAGE_SKID_EN
    seq.push_back(mk(1, 0, 1, 'hB2, 14'h1B2, 0, 1, 1, 'hA1, 14'h1A1, 2, 1));
    seq.push_back(mk(1, 0, 1, 'hB2, 14'h1B2, 0, 0, 1, 'hA1, 14'h1A1, 2, 2));
    seq.push_back(mk(1, 0, 1, 'hB2, 14'h1B2, 0, 0, 1, 'hA1, 14'h1A1, 2, 3));
    seq.push_back(mk(1, 0, 0, 'h0,  14'h0,   1, 0, 1, 'hB2, 14'h1B2, 1, 3));
    seq.push_back(mk(1, 0, 0, 'h0,  14'h0,   1, 1, 0, 'hB2, NOP,     0, 3));
    // Fill both entries, then flush with beat C3 offered: everything disappears.
    seq.push_back(mk(1, 0, 1, 'hC1, 14'h1C1, 0, 1, 1, 'hC1, 14'h1C1, 1, 3));
    seq.push_back(mk(1, 0, 1, 'hC2, 14'h1C2, 0, 1, 1, 'hC1, 14'h1C1, 2, 4));
    seq.push_back(mk(1, 1, 1, 'hC3, 14'h1C3, 0, 0, 0, 'hC1, NOP,     0, 5));
    seq.push_back(mk(1, 0, 0, 'h0,  14'h0,   1, 1, 0, 'hC1, NOP,     0, 5));
`else
    seq.push_back(mk(1, 0, 1, 'hB2, 14'h1B2, 0, 0, 1, 'hA1, 14'h1A1, 1, 1));
    seq.push_back(mk(1, 0, 1, 'hB2, 14'h1B2, 0, 0, 1, 'hA1, 14'h1A1, 1, 2));
    seq.push_back(mk(1, 0, 1, 'hB2, 14'h1B2, 0, 0, 1, 'hA1, 14'h1A1, 1, 3));
    seq.push_back(mk(1, 0, 1, 'hB2, 14'h1B2, 1, 1, 1, 'hB2, 14'h1B2, 1, 3));
    seq.push_back(mk(1, 0, 0, 'h0,  14'h0,   1, 1, 0, 'hB2, NOP,     0, 3));
    // Load, stall twice more, then flush: stall count survives the flush.
    seq.push_back(mk(1, 0, 1, 'hC1, 14'h1C1, 0, 1, 1, 'hC1, 14'h1C1, 1, 3));
    seq.push_back(mk(1, 0, 0, 'h0,  14'h0,   0, 0, 1, 'hC1, 14'h1C1, 1, 4));
    seq.push_back(mk(1, 1, 1, 'hC3, 14'h1C3, 0, 0, 0, 'hC1, NOP,     0, 5));
    seq.push_back(mk(1, 0, 0, 'h0,  14'h0,   1, 1, 0, 'hC1, NOP,     0, 5));
`endif
    // Reload, then reset mid-operation with stall count 5.
    seq.push_back(mk(1, 0, 1, 'hD1, 14'h1D1, 0, 1, 1, 'hD1, 14'h1D1, 1, 5));
    seq.push_back(mk(0, 0, 0, 'h0,  14'h0,   0, SKID, 0, 'h0, NOP,   0, 0));
    foreach (seq[i]) applyStimulus(seq[i], $sformatf("seq%0d", i));

    // Saturation of a 4-bit stall counter on the second instance.
    sat_rst_n = 1'b1; sat_in_valid = 1'b1; sat_in_data = 8'h3C; sat_in_ctrl = 4'hA; sat_out_ready = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("sat.load_valid", {159'd0, sat_out_valid}, 160'd1);
    sat_in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 14) checkOutput("sat.cnt14", {156'd0, sat_stall}, 160'd14);
      if (i == 15) checkOutput("sat.cnt15", {156'd0, sat_stall}, 160'd15);
    end
    checkOutput("sat.cnt_hold", {156'd0, sat_stall}, 160'd15);
    checkOutput("sat.data", {152'd0, sat_out_data}, 160'h3C);
    checkOutput("sat.ctrl", {156'd0, sat_out_ctrl}, 160'hA);
    sat_out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("sat.drain_ctrl", {156'd0, sat_out_ctrl}, 160'h5);
    checkOutput("sat.drain_cnt", {156'd0, sat_stall}, 160'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
